rx_cmd_parser: RTL

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_parser_pkg.sv | 11 +
 rtl/rx_cmd_parser_buf.sv | 36 +++
 rtl/rx_cmd_parser.sv | 101 ++++++++++
 3 files changed

// File: rtl/rx_cmd_parser_pkg.sv
// rx_cmd_parser_pkg: shared FSM states, ASCII codes and defaults for the UART command parser
package rx_cmd_parser_pkg;
  localparam int MAX_LEN_DEF = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RATE_ARG = 3'd1, ST_RATE_END = 3'd2,
                         ST_SDATA = 3'd3, ST_DRAIN = 3'd4, ST_SKIP = 3'd5;
  localparam logic [7:0] A_CR = 8'h0D, A_LF = 8'h0A, A_R = 8'h52, A_S = 8'h53,
                         A_0 = 8'h30, A_3 = 8'h33, A_9 = 8'h39;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= A_0 && b <= A_9;
  endfunction
endpackage

// File: rtl/rx_cmd_parser_buf.sv
// cmd_buf: digit store for one display command with write count and read pointer
module cmd_buf
  import rx_cmd_parser_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int CW = $clog2(MAX_LEN + 1),
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          rd_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          last_o,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [MAX_LEN];
  logic [CW-1:0] cnt_q, rd_q;
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      if (wr_i && !full_o) cnt_q <= cnt_q + 1'b1;
      if (rd_i) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr_i && !full_o) mem_q[cnt_q[AW-1:0]] <= wdata_i;
  assign cnt_o   = cnt_q;
  assign full_o  = cnt_q == CW'(MAX_LEN);
  assign last_o  = rd_q + 1'b1 == cnt_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: parses "R<d>CR" rate and "S<digits>CR" display commands; display digits
// reach the FIFO only after the closing CR, so a broken command never leaks partial data
module rx_cmd_parser
  import rx_cmd_parser_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  input  logic       iFIFO_FULL,
  output logic       oWR_EN,
  output logic [7:0] oWR_DATA,
  output logic [1:0] oRATE,
  output logic       oSTART,
  output logic       oERR,
  output logic       oBUSY
);
  localparam int CW = $clog2(MAX_LEN + 1);
  logic [2:0] state_q, state_d;
  logic [1:0] rate_q, rate_d, prate_q, prate_d;
  logic err_q, err_d, start_q, start_d, clr, wr, full, last;
  logic [CW-1:0] cnt;
  logic [7:0] rdata;
  cmd_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk(clk), .reset(reset), .clr_i(clr), .wr_i(wr), .wdata_i(iRX_DATA), .rd_i(oWR_EN),
    .cnt_o(cnt), .full_o(full), .last_o(last), .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    prate_d = prate_q;
    err_d   = 1'b0;
    start_d = 1'b0;
    clr     = 1'b0;
    wr      = 1'b0;
    if (state_q == ST_DRAIN) begin
      err_d = iRX_VALID;
      if (oWR_EN && last) begin
        state_d = ST_IDLE;
        start_d = 1'b1;
      end
    end else if (iRX_VALID) begin
      case (state_q)
        ST_IDLE:
          if (iRX_DATA == A_R) state_d = ST_RATE_ARG;
          else if (iRX_DATA == A_S) begin
            state_d = ST_SDATA;
            clr     = 1'b1;
          end else if (iRX_DATA != A_CR && iRX_DATA != A_LF) begin
            err_d   = 1'b1;
            state_d = ST_SKIP;
          end
        ST_RATE_ARG:
          if (iRX_DATA >= A_0 && iRX_DATA <= A_3) begin
            prate_d = iRX_DATA[1:0];
            state_d = ST_RATE_END;
          end else begin
            err_d   = 1'b1;
            state_d = (iRX_DATA == A_CR) ? ST_IDLE : ST_SKIP;
          end
        ST_RATE_END: begin
          err_d   = iRX_DATA != A_CR;
          state_d = err_d ? ST_SKIP : ST_IDLE;
          rate_d  = err_d ? rate_q : prate_q;
        end
        ST_SDATA:
          if (is_digit(iRX_DATA) && !full) wr = 1'b1;
          else if (iRX_DATA == A_CR && cnt != '0) state_d = ST_DRAIN;
          else begin
            err_d   = 1'b1;
            state_d = (iRX_DATA == A_CR) ? ST_IDLE : ST_SKIP;
          end
        ST_SKIP: state_d = (iRX_DATA == A_CR) ? ST_IDLE : ST_SKIP;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rate_q  <= 2'b00;
      prate_q <= 2'b00;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      prate_q <= prate_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end
  assign oBUSY    = state_q == ST_DRAIN;
  assign oWR_EN   = oBUSY && !iFIFO_FULL;
  assign oWR_DATA = oWR_EN ? rdata : 8'h00;
  assign oRATE    = rate_q;
  assign oSTART   = start_q;
  assign oERR     = err_q;
endmodule
